// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bundle: PC control from hazard/EX logic, predictor update
// from EX, the instruction-memory port and the IF-side pipeline outputs.
interface if_fetch_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  pc_write;
    logic                  redirect;
    logic [DATA_WIDTH-1:0] redirect_pc;
    logic                  update;
    logic [DATA_WIDTH-1:0] update_pc;
    logic                  update_taken;
    logic [DATA_WIDTH-1:0] update_target;
    logic [DATA_WIDTH-1:0] imem_addr;
    logic [DATA_WIDTH-1:0] imem_rdata;
    logic [DATA_WIDTH-1:0] if_PC;
    logic [DATA_WIDTH-1:0] if_pc_plus_4;
    logic [DATA_WIDTH-1:0] if_instruction;
    logic                  if_pred;

    // Surrounding pipeline / memory side.
    modport master (
        output pc_write, redirect, redirect_pc,
        output update, update_pc, update_taken, update_target,
        output imem_rdata,
        input  imem_addr, if_PC, if_pc_plus_4, if_instruction, if_pred
    );

    // Fetch unit side.
    modport slave (
        input  pc_write, redirect, redirect_pc,
        input  update, update_pc, update_taken, update_target,
        input  imem_rdata,
        output imem_addr, if_PC, if_pc_plus_4, if_instruction, if_pred
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, predicts with a direct-mapped
// BTB plus 2-bit saturating BHT, holds on stall and takes EX redirects.
// All outputs are combinational from the registered state and imem_rdata.
module if_fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    IDX_BITS   = 4
) (
    input  logic          clk,
    input  logic          reset,
    if_fetch_unit_if.slave bus
);
    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_W   = DATA_WIDTH - IDX_BITS - 2;

    typedef logic [IDX_BITS-1:0] idx_t;
    typedef logic [TAG_W-1:0]    tag_t;

    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] next_pc;
    logic [DATA_WIDTH-1:0] pc_plus_4;

    logic [1:0]            bht        [ENTRIES];
    logic [ENTRIES-1:0]    btb_valid;
    tag_t                  btb_tag    [ENTRIES];
    logic [DATA_WIDTH-1:0] btb_target [ENTRIES];

    idx_t fetch_idx, upd_idx;
    tag_t fetch_tag, upd_tag;
    logic pred;
    logic upd_pc_align_unused;

    assign fetch_idx = pc[IDX_BITS+1:2];
    assign fetch_tag = pc[DATA_WIDTH-1:IDX_BITS+2];
    assign upd_idx   = bus.update_pc[IDX_BITS+1:2];
    assign upd_tag   = bus.update_pc[DATA_WIDTH-1:IDX_BITS+2];
    // Word-offset bits of the resolved PC carry no predictor information.
    assign upd_pc_align_unused = &bus.update_pc[1:0];

    assign pc_plus_4 = pc + DATA_WIDTH'(4);
    assign pred      = btb_valid[fetch_idx] && (btb_tag[fetch_idx] == fetch_tag)
                       && bht[fetch_idx][1];

    assign bus.imem_addr      = pc;
    assign bus.if_PC          = pc;
    assign bus.if_pc_plus_4   = pc_plus_4;
    assign bus.if_instruction = bus.imem_rdata;
    assign bus.if_pred        = pred;

    // Next-PC select: redirect beats stall beats prediction beats sequential.
    always_comb begin
        // NOTE: the default assignment first means every path drives next_pc,
        // so no latch is inferred.
        next_pc = pc_plus_4;
        if (bus.redirect)
            next_pc = bus.redirect_pc;
        else if (!bus.pc_write)
            next_pc = pc;
        else if (pred)
            next_pc = btb_target[fetch_idx];
        // Fetch addresses are always word aligned, whatever the source.
        next_pc[1:0] = 2'b00;
    end

    // PC register, reset asynchronously to RESET_PC.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments for all sequential state so every
        // register samples pre-edge values.
        if (reset)
            pc <= RESET_PC;
        else
            pc <= next_pc;
    end

    // Direction counters and BTB valid bits; these need a known reset state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++)
                bht[i] <= 2'b01;
            btb_valid <= '0;
        end else if (bus.update) begin
            // Untagged counter: trains whatever instruction maps to the index.
            if (bus.update_taken && bht[upd_idx] != 2'b11)
                bht[upd_idx] <= bht[upd_idx] + 2'b01;
            else if (!bus.update_taken && bht[upd_idx] != 2'b00)
                bht[upd_idx] <= bht[upd_idx] - 2'b01;
            if (bus.update_taken)
                btb_valid[upd_idx] <= 1'b1;
        end
    end

    // BTB tag/target storage, written on taken resolutions only.
    always_ff @(posedge clk) begin
        // NOTE: tags and targets are not reset; btb_valid masks them, which
        // keeps this storage a plain RAM without a reset network.
        if (bus.update && bus.update_taken) begin
            btb_tag[upd_idx]    <= upd_tag;
            btb_target[upd_idx] <= bus.update_target;
        end
    end
endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: stimulus pushes hand-computed expected
// fetch state into a queue; the monitor pops and compares on each sample.
module tb_if_fetch_unit;
    localparam int DW = 32;

    typedef struct {
        string     name;
        logic [31:0] pc;
        logic        pred;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_pass  = 0;
    int   n_total = 0;
    exp_t sb_q[$];
    event sample_ev;

    if_fetch_unit_if #(.DATA_WIDTH(DW)) bus ();

    if_fetch_unit #(.DATA_WIDTH(DW), .RESET_PC(32'h0), .IDX_BITS(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Instruction memory model: data is a fixed function of the address.
    assign bus.imem_rdata = ~bus.imem_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Monitor: compares every presented sample against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(sample_ev);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check({e.name, ".if_PC"},          bus.if_PC,          e.pc);
                check({e.name, ".imem_addr"},      bus.imem_addr,      e.pc);
                check({e.name, ".if_pc_plus_4"},   bus.if_pc_plus_4,   e.pc + 32'd4);
                check({e.name, ".if_instruction"}, bus.if_instruction, ~e.pc);
                check({e.name, ".if_pred"},        {31'd0, bus.if_pred}, {31'd0, e.pred});
            end
        end
    end

    task automatic expect_now(input string name, input logic [31:0] pc, input logic pred);
        exp_t e;
        e.name = name;
        e.pc   = pc;
        e.pred = pred;
        sb_q.push_back(e);
        ->sample_ev;
        #0;
    endtask

    task automatic expect_mid(input string name, input logic [31:0] pc, input logic pred);
        @(negedge clk);
        expect_now(name, pc, pred);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic visit(input logic [31:0] a);
        bus.redirect    = 1'b1;
        bus.redirect_pc = a;
        nxt();
        bus.redirect    = 1'b0;
    endtask

    task automatic upd(input logic [31:0] a, input logic taken, input logic [31:0] tgt);
        bus.update        = 1'b1;
        bus.update_pc     = a;
        bus.update_taken  = taken;
        bus.update_target = tgt;
        nxt();
        bus.update        = 1'b0;
    endtask

    task automatic reset_pulse();
        #1 reset = 1'b1;
        #1 expect_now("rst_async", 32'h0, 1'b0);
        #1 reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset             = 1'b1;
        bus.pc_write      = 1'b1;
        bus.redirect      = 1'b0;
        bus.redirect_pc   = '0;
        bus.update        = 1'b0;
        bus.update_pc     = '0;
        bus.update_taken  = 1'b0;
        bus.update_target = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Sequential fetch from reset, then a mid-cycle reset pulse.
        expect_mid("rst_init", 32'h0, 1'b0);
        nxt(); expect_mid("seq4", 32'h4, 1'b0);
        nxt(); expect_mid("seq8", 32'h8, 1'b0);
        nxt(); expect_mid("seqC", 32'hC, 1'b0);
        reset_pulse();
        nxt(); expect_mid("post_rst4", 32'h4, 1'b0);

        // Stall for three edges at 0x8, then redirect while still stalled.
        nxt(); bus.pc_write = 1'b0;
        expect_mid("stall0", 32'h8, 1'b0);
        repeat (2) begin
            nxt(); expect_mid("stall", 32'h8, 1'b0);
        end
        nxt();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h103;
        expect_mid("stall3", 32'h8, 1'b0);
        nxt();
        bus.redirect = 1'b0;
        bus.pc_write = 1'b1;

        // Redirect and training update in the same cycle: 0x10 -> 0x40, bht 01->10.
        bus.update        = 1'b1;
        bus.update_pc     = 32'h10;
        bus.update_taken  = 1'b1;
        bus.update_target = 32'h40;
        bus.redirect      = 1'b1;
        bus.redirect_pc   = 32'hC;
        expect_mid("redir", 32'h100, 1'b0);
        nxt();
        bus.update   = 1'b0;
        bus.redirect = 1'b0;
        expect_mid("walkC", 32'hC, 1'b0);
        nxt(); expect_mid("train_hit", 32'h10, 1'b1);
        nxt(); expect_mid("train_tgt", 32'h40, 1'b0);

        // Saturation: 10 -> 11, then not-taken down to 00 and below.
        upd(32'h10, 1'b1, 32'h40);                 // 11
        upd(32'h10, 1'b0, 32'h0);                  // 10
        visit(32'h10); expect_mid("nt1", 32'h10, 1'b1);
        nxt();         expect_mid("nt1_tgt", 32'h40, 1'b0);
        upd(32'h10, 1'b0, 32'h0);                  // 01
        visit(32'h10); expect_mid("nt2", 32'h10, 1'b0);
        nxt();         expect_mid("nt2_seq", 32'h14, 1'b0);
        upd(32'h10, 1'b0, 32'h0);                  // 00
        visit(32'h10); expect_mid("nt3", 32'h10, 1'b0);
        upd(32'h10, 1'b0, 32'h0);                  // stays 00
        upd(32'h10, 1'b1, 32'h40);                 // 01
        visit(32'h10); expect_mid("sat_low", 32'h10, 1'b0);
        upd(32'h10, 1'b1, 32'h40);                 // 10
        visit(32'h10); expect_mid("t2", 32'h10, 1'b1);
        nxt();         expect_mid("t2_tgt", 32'h40, 1'b0);

        // Aliasing: 0x50 shares index 4 with 0x10 but has a different tag.
        upd(32'h10, 1'b1, 32'h40);                 // 11
        visit(32'h50); expect_mid("alias_miss", 32'h50, 1'b0);
        nxt();         expect_mid("alias_seq", 32'h54, 1'b0);
        upd(32'h50, 1'b1, 32'h80);
        visit(32'h50); expect_mid("alias_hit", 32'h50, 1'b1);
        nxt();         expect_mid("alias_tgt", 32'h80, 1'b0);
        visit(32'h10); expect_mid("evicted", 32'h10, 1'b0);
        nxt();         expect_mid("evicted_seq", 32'h14, 1'b0);

        // Same-cycle collision from a clean predictor: prediction uses old state.
        reset_pulse();
        visit(32'h10);
        bus.update        = 1'b1;
        bus.update_pc     = 32'h10;
        bus.update_taken  = 1'b1;
        bus.update_target = 32'h40;
        expect_mid("collide", 32'h10, 1'b0);
        nxt();
        bus.update = 1'b0;
        expect_mid("collide_seq", 32'h14, 1'b0);
        visit(32'h10); expect_mid("collide_hit", 32'h10, 1'b1);
        nxt();         expect_mid("collide_tgt", 32'h40, 1'b0);

        // Misaligned BTB target is forced to a word boundary.
        upd(32'h30, 1'b1, 32'h7B);
        visit(32'h30); expect_mid("align_hit", 32'h30, 1'b1);
        nxt();         expect_mid("align_tgt", 32'h78, 1'b0);

        // PC + 4 wraps at the top of the address space.
        visit(32'hFFFF_FFFC); expect_mid("wrap_top", 32'hFFFF_FFFC, 1'b0);
        nxt();                expect_mid("wrap_zero", 32'h0, 1'b0);

        #1;
        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage front end that owns the program counter and drives the IF side of the IF/ID pipeline register: `if_PC`, `if_pc_plus_4`, `if_instruction` and `if_pred`. It predicts branches with a direct-mapped BTB and 2-bit saturating-counter BHT, holds the PC on stall, and takes redirects from EX on mispredict. EX updates the predictor state when a branch or jump resolves.

## Interface

- `DATA_WIDTH`, 32, PC/instruction width
- `RESET_PC`, 32'h0, PC value loaded by reset
- `IDX_BITS`, 4, log2 of predictor entries (16 entries)

- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `pc_write`  in  1  1 = advance PC; 0 = stall (hold PC)
- `redirect`  in  1  EX mispredict; load `redirect_pc`
- `redirect_pc`  in  DATA_WIDTH  corrected fetch address
- `update`  in  1  EX resolved a branch/jump this cycle
- `update_pc`  in  DATA_WIDTH  PC of the resolved instruction
- `update_taken`  in  1  actual direction
- `update_target`  in  DATA_WIDTH  actual taken target
- `imem_addr`  out  DATA_WIDTH  instruction memory address (= PC)
- `imem_rdata`  in  DATA_WIDTH  instruction memory data (combinational read)
- `if_PC`  out  DATA_WIDTH  current fetch PC
- `if_pc_plus_4`  out  DATA_WIDTH  PC + 4
- `if_instruction`  out  DATA_WIDTH  = `imem_rdata`
- `if_pred`  out  1  predicted taken for current PC

## Operation

- State: `pc` register; per entry i, 2 bits `bht[i]`, 1 bit `btb_valid[i]`, `btb_tag[i]` = DATA_WIDTH-IDX_BITS-2 bits, `btb_target[i]` = DATA_WIDTH bits.
- Index = `pc[IDX_BITS+1:2]`. Tag = `pc[DATA_WIDTH-1:IDX_BITS+2]`.
- Prediction (combinational from `pc`): `if_pred` = `btb_valid[idx]` AND tag match AND `bht[idx][1]`.
- Next-PC priority, highest first: `redirect` → `redirect_pc`; `!pc_write` → hold `pc`; `if_pred` → `btb_target[idx]`; else `pc + 4`. Redirect overrides stall.
- PC bits [1:0] are forced to 0 on every load, including `redirect_pc` and BTB targets.
- PC + 4 wraps modulo 2^DATA_WIDTH.
- Update, when `update` = 1, at the update index/tag:
  - `bht` saturates upward on taken (max 2'b11) and downward on not-taken (min 2'b00). The BHT is untagged, so it updates regardless of tag.
  - On taken, the BTB entry is written with `valid`=1, tag and `update_target`. This replaces any aliasing entry.
  - On not-taken, the BTB is unchanged.
- Read-before-write: a prediction and an update to the same entry in the same cycle. The prediction uses the pre-update state.
- Reset values:
  - `pc` = RESET_PC, so `if_PC`=RESET_PC, `if_pc_plus_4`=RESET_PC+4 and `if_pred`=0.
  - All `bht` = 2'b01 (weakly not-taken).
  - All `btb_valid` = 0. Tags and targets are don't-care.

## Timing

- All outputs are combinational from the registers and `imem_rdata`; no output flops.
- Redirect, stall and prediction affect `pc` at the next rising edge (latency 1). A redirect asserted in cycle N gives `if_PC`=`redirect_pc` in cycle N+1.
- Update asserted in cycle N is visible to prediction from cycle N+1.
- Reset asserted mid-operation immediately forces the reset values, independent of `clk`. The first edge after deassertion advances from RESET_PC.
- `redirect` and `update` for the same branch in the same cycle are legal and both take effect.

## Test plan

- Reset: pulse `reset` mid-cycle with `pc_write`=1 and no updates → `if_PC`=0x0 immediately and `if_pred`=0. Subsequent edges give `if_PC` = 0x4, 0x8, 0xC with `if_pc_plus_4` = `if_PC`+4.
- Stall/redirect: at `if_PC`=0x8 hold `pc_write`=0 for 3 cycles → `if_PC` stays 0x8. Then assert `redirect`=1 with `redirect_pc`=0x103 while still stalled → next cycle `if_PC`=0x100.
- Training: one update (`update_pc`=0x10, taken, target 0x40) moves bht 01→10. Fetch reaching 0x10 → `if_pred`=1, and the next `if_PC`=0x40.
- Saturation:
  - Three not-taken updates at 0x10 from 11 → 00, `if_pred`=0 at 0x10.
  - A 4th not-taken update stays 00.
  - Then one taken → 01 (pred 0); a second taken → 10 (pred 1).
- Aliasing: train 0x10 taken to 0x40 (bht 11). Fetch 0x50 (same index 4, different tag) → `if_pred`=0 and next PC 0x54. A taken update at 0x50 to 0x80 → 0x50 predicts 0x80, and 0x10 now misses the BTB (`if_pred`=0).
- Same-cycle collision: at `if_PC`=0x10 with bht=01, assert a taken update for 0x10 → `if_pred`=0 that cycle. The next visit to 0x10 gives `if_pred`=1.
